// File: rtl/call_stack.sv
// Return-address stack for the MUSA core: CALL pushes the return PC, RET pops it, tail-call replaces the top.
// Build option CALL_STACK_GUARD_EN: drop pushes on a full stack; when undefined, a full push overwrites the oldest entry.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          clr_err,
  output logic [AW-1:0] top_addr,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  localparam int SPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW:0]   CNT_ONE = (SPW+1)'(1);
  localparam logic [SPW:0]   CNT_MAX = (SPW+1)'(DEPTH);
`ifdef CALL_STACK_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [SPW:0]   r_count;
  logic           r_overflow;
  logic           r_underflow;

  logic [SPW-1:0] w_sp_m1;
  logic           w_empty, w_full;
  logic           w_req_push, w_req_pop, w_req_repl;
  logic           w_do_push, w_do_pop, w_do_repl;
  logic           w_ov_ev, w_un_ev;

  assign w_sp_m1 = r_sp - SP_ONE;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_MAX);

  assign w_req_push = step &  push & ~pop;
  assign w_req_pop  = step & ~push &  pop;
  assign w_req_repl = step &  push &  pop;

  // A tail call on an empty stack has no top to overwrite, so it becomes a plain push.
  assign w_do_push = (w_req_push | (w_req_repl & w_empty)) & ~(GUARD & w_full);
  assign w_do_repl = w_req_repl & ~w_empty;
  assign w_do_pop  = w_req_pop  & ~w_empty;

  assign w_ov_ev = w_req_push & w_full;
  assign w_un_ev = w_req_pop  & w_empty;

  // Storage is deliberately left out of reset; count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push)      r_mem[r_sp]    <= push_addr;
    else if (w_do_repl) r_mem[w_sp_m1] <= push_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_sp <= r_sp + SP_ONE;
        if (!w_full) r_count <= r_count + CNT_ONE;
      end else if (w_do_pop) begin
        r_sp    <= w_sp_m1;
        r_count <= r_count - CNT_ONE;
      end
      r_overflow  <= (r_overflow  & ~clr_err) | w_ov_ev;
      r_underflow <= (r_underflow & ~clr_err) | w_un_ev;
    end
  end

  assign top_addr  = w_empty ? '0 : r_mem[w_sp_m1];
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios then random traffic against a queue-based model.
module tb_call_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic [AW-1:0] top_addr;
  logic          empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] q[$];
  bit ov_m = 0, un_m = 0;

  call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .push(push), .pop(pop),
    .push_addr(push_addr), .clr_err(clr_err), .top_addr(top_addr),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] mtop();
    return (q.size() == 0) ? '0 : q[q.size()-1];
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".top"},   top_addr, mtop());
    chk({tag, ".empty"}, AW'(empty), AW'(q.size() == 0));
    chk({tag, ".full"},  AW'(full), AW'(q.size() == DEPTH));
    chk({tag, ".ovf"},   AW'(overflow), AW'(ov_m));
    chk({tag, ".unf"},   AW'(underflow), AW'(un_m));
  endtask

  task automatic model(input bit st, input bit pu, input bit po, input logic [AW-1:0] a, input bit clr);
    bit ov_ev, un_ev;
    ov_ev = st && pu && !po && (q.size() == DEPTH);
    un_ev = st && po && !pu && (q.size() == 0);
    if (st) begin
      if (pu && !po) begin
        if (q.size() < DEPTH) q.push_back(a);
        else begin
`ifndef CALL_STACK_GUARD_EN
          void'(q.pop_front());
          q.push_back(a);
`endif
        end
      end else if (pu && po) begin
        if (q.size() == 0) q.push_back(a);
        else q[q.size()-1] = a;
      end else if (po && !pu) begin
        if (q.size() > 0) void'(q.pop_back());
      end
    end
    ov_m = (ov_m && !clr) || ov_ev;
    un_m = (un_m && !clr) || un_ev;
  endtask

  // One clock: drive after falling edge, check pre-edge top (consumer view), then post-edge state.
  task automatic cyc(input bit st, input bit pu, input bit po, input logic [AW-1:0] a, input bit clr, input string tag);
    @(negedge clk);
    step = st; push = pu; pop = po; push_addr = a; clr_err = clr;
    #1 chk({tag, ".pre"}, top_addr, mtop());
    @(posedge clk);
    model(st, pu, po, a, clr);
    #1 chk_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; step = 0; push = 0; pop = 0; clr_err = 0;
    q.delete(); ov_m = 0; un_m = 0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] v;
    do_reset();

    // step=0 must leave everything alone
    cyc(0, 1, 0, 32'hdead, 0, "idle_push");
    cyc(0, 0, 1, 32'hbeef, 0, "idle_pop");
    cyc(0, 1, 1, 32'h1234, 0, "idle_repl");

    // LIFO order
    cyc(1, 1, 0, 32'h10, 0, "p10");
    cyc(1, 1, 0, 32'h20, 0, "p20");
    cyc(1, 1, 0, 32'h30, 0, "p30");
    chk("lifo.top30", top_addr, 32'h30);
    cyc(1, 0, 1, 0, 0, "pop1");
    cyc(1, 0, 1, 0, 0, "pop2");
    chk("lifo.top10", top_addr, 32'h10);
    cyc(1, 0, 1, 0, 0, "pop3");
    chk("lifo.empty", AW'(empty), 32'h1);

    // Fill, then push into a full stack
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 32'h100 + i, 0, "fill");
    chk("fill.full", AW'(full), 32'h1);
    cyc(1, 1, 0, 32'h200, 0, "ovpush");
`ifdef CALL_STACK_GUARD_EN
    chk("ov.top", top_addr, 32'h107);
`else
    chk("ov.top", top_addr, 32'h200);
`endif
    chk("ov.flag", AW'(overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0, "drain");

    // Underflow, then clear
    cyc(1, 0, 1, 0, 0, "unpop");
    chk("un.flag", AW'(underflow), 32'h1);
    chk("un.top", top_addr, 32'h0);
    cyc(0, 0, 0, 0, 1, "clr");
    chk("clr.unf", AW'(underflow), 32'h0);
    // Clear and a new error in the same cycle: error wins
    cyc(1, 0, 1, 0, 1, "clr_vs_err");

    // Tail call replaces the top
    cyc(0, 0, 0, 0, 1, "clr2");
    cyc(1, 1, 0, 32'h40, 0, "p40");
    cyc(1, 1, 1, 32'h50, 0, "repl50");
    chk("repl.top", top_addr, 32'h50);
    cyc(1, 0, 1, 0, 0, "replpop");
    chk("repl.empty", AW'(empty), 32'h1);
    cyc(1, 1, 1, 32'h55, 0, "repl_empty");

    // Asynchronous reset between edges
    cyc(1, 1, 0, 32'h60, 0, "p60");
    cyc(1, 1, 0, 32'h70, 0, "p70");
    @(negedge clk);
    step = 0; push = 0; pop = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset.empty", AW'(empty), 32'h1);
    chk("areset.top", top_addr, 32'h0);
    q.delete(); ov_m = 0; un_m = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with alternating push/pop bias to hit both ends
    for (int i = 0; i < 600; i++) begin
      bit st, pu, po, clr;
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      st  = ($urandom_range(99) < 80);
      pu  = ($urandom_range(99) < bias);
      po  = ($urandom_range(99) < (100 - bias));
      clr = ($urandom_range(99) < 10);
      v   = $urandom;
      cyc(st, pu, po, v, clr, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/call_stack.md
# call_stack

Hardware return-address stack for the MUSA core, sitting directly downstream of the ID-stage control unit. On a CALL it stores the return PC supplied by the fetch path. On a RET it presents the stored PC as the jump target and removes it. Push/pop requests come from the control unit and are qualified by a one-cycle step strobe, so a multi-cycle instruction acts on the stack exactly once.

## Interface
- DEPTH, 8: number of entries; power of two, 2..64.
- AW, 32: address width of stored PCs.
- clk  input  1  core clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- step  input  1  one-cycle strobe (the PCWrite pulse); push/pop are ignored unless step=1.
- push  input  1  CALL request from control unit.
- pop  input  1  RET request from control unit.
- push_addr  input  AW  return PC (CALL PC + 1) to store.
- top_addr  output  AW  current top-of-stack entry; 0 when empty.
- empty  output  1  no valid entries.
- full  output  1  DEPTH valid entries.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.
- clr_err  input  1  synchronous clear of overflow/underflow.

## Operation
- Storage: DEPTH x AW register array; pointer sp (log2(DEPTH) bits) indexes the next free slot; count (log2(DEPTH)+1 bits) tracks valid entries.
- top_addr = mem[sp-1] (modulo DEPTH) when count>0, else 0. Combinational from registered state.
- Only these events act; each needs step=1:
  - PUSH (push=1, pop=0): mem[sp] <= push_addr; sp <= sp+1; count <= count+1.
  - POP (push=0, pop=1): sp <= sp-1; count <= count-1. The consumer samples top_addr in the same cycle as the pop.
  - REPLACE (push=1, pop=1): mem[sp-1] <= push_addr; sp and count unchanged. Tail call. When empty, it behaves as PUSH.
- step=0: no state change, whatever push/pop are.
- Pointer arithmetic wraps modulo DEPTH.
- Full/empty behaviour depends on CALL_STACK_GUARD_EN (see Configuration).
- clr_err=1 clears overflow and underflow in that cycle. A new error event in the same cycle wins, so the flag is set.

## Timing
- Reset (async, rst_n=0) sets:
  - sp=0, count=0
  - empty=1, full=0
  - overflow=0, underflow=0
  - top_addr=0
  - Array contents are not reset.
- Latency: a PUSH at edge N makes top_addr=push_addr visible after edge N. A POP at edge N shows the previous entry after edge N.
- empty and full are decoded from registered count; no combinational path from push/pop.
- Reset asserted mid-operation discards all entries immediately, with no clock needed.
- Only one event per step. Back-to-back steps on consecutive cycles are legal.

## Configuration
- CALL_STACK_GUARD_EN defined:
  - PUSH while full: the push is dropped, the stack is unchanged, overflow is set.
  - POP while empty: the pop is dropped, top_addr stays 0, underflow is set.
- CALL_STACK_GUARD_EN undefined (circular mode):
  - PUSH while full overwrites the oldest entry. sp advances, count saturates at DEPTH, overflow is set.
  - POP while empty is a no-op on state, and underflow is set.
- Both modes set the sticky flags identically. Only the full-push data behaviour differs.

## Test plan
- Reset then idle: rst_n low 2 cycles -> empty=1, full=0, top_addr=0, both flags 0. Toggling push/pop with step=0 changes nothing.
- Push 0x10, 0x20, 0x30 (DEPTH=8) with step, then 3 pops -> top_addr reads 0x30, 0x20, 0x10 in the pop cycles. empty=1 after the third pop.
- Push 0x100..0x107 to fill (full=1), then push 0x200:
  - guard mode: top_addr stays 0x107, overflow=1.
  - circular mode: top_addr=0x200; popping 8 times yields 0x200, 0x107..0x101.
- Pop on empty -> underflow=1, top_addr=0, count stays 0. clr_err pulse -> underflow=0.
- Push 0x40, then push=pop=1 with push_addr=0x50 -> top_addr=0x50, count=1. A single pop -> empty=1.
- Push 0x60, 0x70, then assert rst_n=0 between clock edges -> empty=1 and top_addr=0 immediately, before the next rising edge.
